pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//   Fetch-stage PC controller, downstream consumer of the branch decision.
//   Holds the program counter and selects the next PC: sequential, branch/jump redirect, stall, or halt.
//   Generates pipeline flush strobes for IF/ID and ID/EX, and a fetch-valid qualifier for the synchronous I-memory.
//   Keeps a saturating count of taken redirects for performance debug.
// PARAMETERS
//   XLEN      32    datapath / PC width
//   RESET_PC  0     PC value loaded on reset
//   CNT_W     16    width of redirect_count
// PORTS
//   clk            in   1       rising-edge clock
//   rst            in   1       synchronous, active-high reset
//   stall          in   1       load-use hazard: hold PC
//   branch_taken   in   1       resolved conditional branch taken (EX stage)
//   jump           in   1       JAL/JALR in EX stage
//   target         in   XLEN    redirect target address (EX stage)
//   halt           in   1       ECALL/EBREAK/FENCE-halt reached EX
//   pc             out  XLEN    current fetch address (registered)
//   pc_plus4       out  XLEN    pc + 4, modulo 2^XLEN
//   fetch_valid    out  1       I-mem data for this cycle is a real instruction
//   flush_ifid     out  1       squash IF/ID register this cycle
//   flush_idex     out  1       squash ID/EX register this cycle
//   halted         out  1       core stopped
//   misalign_err   out  1       sticky: redirect target not 4-byte aligned
//   redirect_count out  CNT_W   number of accepted redirects, saturating
// BEHAVIOUR
//   Reset (rst=1 at posedge): pc=RESET_PC, state=RUN, halted=0, misalign_err=0, redirect_count=0.
//     flush_* outputs are 0 while rst=1. fetch_valid is 0 while rst=1.
//   Let redirect = branch_taken | jump.
//   Priority each cycle: halt > misaligned redirect > redirect > stall > sequential.
//   States:
//     RUN:
//       fetch_valid=1.
//       halt: pc holds; flush_ifid=flush_idex=1 this cycle; next state is HALTED.
//       Redirect with target[1:0]!=0: treated as halt; misalign_err set; pc holds.
//       Redirect with target aligned:
//         pc<=target; flush_ifid=flush_idex=1 this cycle (combinational).
//         redirect_count+1; next state is RECOVER.
//         stall is ignored in the same cycle.
//       stall only: pc holds; no flush.
//       Otherwise: pc<=pc_plus4.
//     RECOVER (exactly 1 cycle after a redirect; I-mem returns stale word):
//       fetch_valid=0.
//       halt/redirect handled as in RUN; a redirect restarts RECOVER.
//       stall: pc holds; remain in RECOVER.
//       Otherwise: pc<=pc_plus4; next state is RUN.
//     HALTED:
//       fetch_valid=0; halted=1; pc frozen; flush outputs 0; all inputs ignored.
//       Exit only via rst.
//   Arithmetic:
//     pc_plus4 wraps: 0xFFFFFFFC -> 0x00000000.
//     redirect_count saturates at all-ones and does not wrap.
//   Reset mid-operation: rst wins over every input in the same cycle; state returns to RUN next cycle.
//   Flush outputs are combinational from the inputs and state. pc, halted, misalign_err and redirect_count are registered.
// TESTING
//   1. Reset, then 4 free cycles -> pc = 0, 4, 8, 12, 16; fetch_valid=1; no flush.
//   2. pc=0x20, branch_taken=1, target=0x100 -> flush_ifid=flush_idex=1 that cycle; next pc=0x100.
//      Then fetch_valid=0 for 1 cycle; then pc=0x104 and RUN; redirect_count=1.
//   3. stall=1 for 3 cycles at pc=0x40 -> pc stays 0x40; then 0x44.
//      stall=1 together with jump to 0x80 -> pc=0x80 (redirect wins).
//   4. jump with target=0x102 -> misalign_err=1; halted=1 next cycle; pc frozen.
//      Further branches ignored until rst.
//   5. Second redirect during RECOVER (target 0x200, then 0x300) -> pc=0x300; RECOVER extended.
//      Count reaches 2. Also: load count=0xFFFF, redirect once more -> count stays 0xFFFF.
//   6. pc=0xFFFFFFFC, free run -> pc=0x0. Assert rst during RECOVER -> pc=RESET_PC, RUN, count=0.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage PC select with flush, recover, halt and redirect counting
module pc_fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic [XLEN-1:0]  target,
    input  logic             halt,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             fetch_valid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_count
);
    typedef enum logic [1:0] {RUN, RECOVER, HALTED} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush;
    logic             redirect;
    logic             misalign;

    assign redirect       = branch_taken | jump;
    assign misalign       = redirect & (target[1:0] != 2'b00);
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + XLEN'(4);
    assign flush_ifid     = flush;
    assign flush_idex     = flush;
    assign halted         = state_q == HALTED;
    assign misalign_err   = err_q;
    assign redirect_count = cnt_q;
    assign fetch_valid    = ~rst & (state_q == RUN);

    // next-state selection: halt > misaligned redirect > redirect > stall > sequential
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        flush   = 1'b0;
        if (state_q != HALTED) begin
            if (halt || misalign) begin
                state_d = HALTED;
                flush   = 1'b1;
                err_d   = err_q | ~halt;
            end else if (redirect) begin
                state_d = RECOVER;
                pc_d    = target;
                flush   = 1'b1;
                cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
            end else if (!stall) begin
                state_d = RUN;
                pc_d    = pc_plus4;
            end
        end
        if (rst) flush = 1'b0;
    end

    // state registers with synchronous reset overriding every input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenario tests for pc_fetch_ctrl
module tb_pc_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] target = '0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        halted;
    logic        misalign_err;
    logic [15:0] redirect_count;
    int          passed = 0;
    int          total = 0;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .jump(jump),
        .target(target), .halt(halt), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .halted(halted),
        .misalign_err(misalign_err), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch_taken = 0; jump = 0; halt = 0; target = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1; halt = 1; jump = 1; target = 32'h100;
        step(); step();
        total++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want 0", pc); else passed++;
        total++; if ({fetch_valid, flush_ifid, flush_idex} !== 3'b000) $display("FAIL reset_fv_flush got %b want 000", {fetch_valid, flush_ifid, flush_idex}); else passed++;
        idle(); rst = 0; #1;
        total++; if ({fetch_valid, halted, misalign_err} !== 3'b100) $display("FAIL reset_flags got %b want 100", {fetch_valid, halted, misalign_err}); else passed++;
        total++; if (redirect_count !== 16'd0) $display("FAIL reset_count got %0d want 0", redirect_count); else passed++;
        for (int i = 1; i <= 4; i++) begin
            step();
            total++; if (pc !== 32'(4 * i)) $display("FAIL seq_pc%0d got %h want %h", i, pc, 32'(4 * i)); else passed++;
            total++; if ({fetch_valid, flush_ifid} !== 2'b10) $display("FAIL seq_fv%0d got %b want 10", i, {fetch_valid, flush_ifid}); else passed++;
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 4; i++) step();
        total++; if (pc !== 32'h20) $display("FAIL br_start got %h want 20", pc); else passed++;
        branch_taken = 1; target = 32'h100; #1;
        total++; if ({flush_ifid, flush_idex, fetch_valid} !== 3'b111) $display("FAIL br_flush got %b want 111", {flush_ifid, flush_idex, fetch_valid}); else passed++;
        step(); idle(); #1;
        total++; if (pc !== 32'h100) $display("FAIL br_pc got %h want 100", pc); else passed++;
        total++; if ({fetch_valid, flush_ifid} !== 2'b00) $display("FAIL br_recover got %b want 00", {fetch_valid, flush_ifid}); else passed++;
        total++; if (redirect_count !== 16'd1) $display("FAIL br_count got %0d want 1", redirect_count); else passed++;
        step();
        total++; if (pc !== 32'h104) $display("FAIL br_next got %h want 104", pc); else passed++;
        total++; if (fetch_valid !== 1'b1) $display("FAIL br_run got %b want 1", fetch_valid); else passed++;
    endtask

    task automatic test_stall();
        jump = 1; target = 32'h3c; step(); idle(); step();
        total++; if ({pc, fetch_valid} !== {32'h40, 1'b1}) $display("FAIL st_start got %h/%b want 40/1", pc, fetch_valid); else passed++;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({pc, flush_ifid, fetch_valid} !== {32'h40, 2'b01}) $display("FAIL st_hold%0d got %h/%b/%b want 40/0/1", i, pc, flush_ifid, fetch_valid); else passed++;
        end
        stall = 0; step();
        total++; if (pc !== 32'h44) $display("FAIL st_release got %h want 44", pc); else passed++;
        stall = 1; jump = 1; target = 32'h80; #1;
        total++; if (flush_idex !== 1'b1) $display("FAIL st_jflush got %b want 1", flush_idex); else passed++;
        step(); idle(); #1;
        total++; if (pc !== 32'h80) $display("FAIL st_jpc got %h want 80", pc); else passed++;
        total++; if (redirect_count !== 16'd3) $display("FAIL st_count got %0d want 3", redirect_count); else passed++;
        stall = 1; step();
        total++; if ({pc, fetch_valid} !== {32'h80, 1'b0}) $display("FAIL st_recover got %h/%b want 80/0", pc, fetch_valid); else passed++;
        stall = 0; step();
        total++; if ({pc, fetch_valid} !== {32'h84, 1'b1}) $display("FAIL st_recexit got %h/%b want 84/1", pc, fetch_valid); else passed++;
    endtask

    task automatic test_misalign();
        jump = 1; target = 32'h102; #1;
        total++; if (flush_ifid !== 1'b1) $display("FAIL mis_flush got %b want 1", flush_ifid); else passed++;
        step(); idle(); #1;
        total++; if ({halted, misalign_err, fetch_valid} !== 3'b110) $display("FAIL mis_state got %b want 110", {halted, misalign_err, fetch_valid}); else passed++;
        total++; if (pc !== 32'h84) $display("FAIL mis_pc got %h want 84", pc); else passed++;
        branch_taken = 1; target = 32'h200; #1;
        total++; if (flush_ifid !== 1'b0) $display("FAIL halt_flush got %b want 0", flush_ifid); else passed++;
        step(); step();
        total++; if ({pc, redirect_count} !== {32'h84, 16'd3}) $display("FAIL halt_frozen got %h/%0d want 84/3", pc, redirect_count); else passed++;
        do_reset();
        total++; if ({halted, misalign_err, pc} !== {2'b00, 32'h0}) $display("FAIL mis_clear got %b/%b/%h want 0/0/0", halted, misalign_err, pc); else passed++;
        halt = 1; jump = 1; target = 32'h102; step(); idle(); #1;
        total++; if ({halted, misalign_err} !== 2'b10) $display("FAIL halt_prio got %b want 10", {halted, misalign_err}); else passed++;
        total++; if (pc !== 32'h0) $display("FAIL halt_pc got %h want 0", pc); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        jump = 1; target = 32'h200; step();
        total++; if ({pc, fetch_valid} !== {32'h200, 1'b0}) $display("FAIL b2b_first got %h/%b want 200/0", pc, fetch_valid); else passed++;
        branch_taken = 1; jump = 0; target = 32'h300; #1;
        total++; if (flush_idex !== 1'b1) $display("FAIL b2b_flush got %b want 1", flush_idex); else passed++;
        step(); idle(); #1;
        total++; if ({pc, fetch_valid} !== {32'h300, 1'b0}) $display("FAIL b2b_second got %h/%b want 300/0", pc, fetch_valid); else passed++;
        total++; if (redirect_count !== 16'd2) $display("FAIL b2b_count got %0d want 2", redirect_count); else passed++;
        step();
        total++; if ({pc, fetch_valid} !== {32'h304, 1'b1}) $display("FAIL b2b_exit got %h/%b want 304/1", pc, fetch_valid); else passed++;
    endtask

    task automatic test_saturate();
        jump = 1; target = 32'h400;
        for (int i = 0; i < 65532; i++) step();
        total++; if (redirect_count !== 16'hFFFE) $display("FAIL sat_pre got %h want fffe", redirect_count); else passed++;
        step();
        total++; if (redirect_count !== 16'hFFFF) $display("FAIL sat_max got %h want ffff", redirect_count); else passed++;
        step(); step();
        total++; if (redirect_count !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", redirect_count); else passed++;
        total++; if (pc !== 32'h400) $display("FAIL sat_pc got %h want 400", pc); else passed++;
        idle(); step();
    endtask

    task automatic test_wrap();
        do_reset();
        jump = 1; target = 32'hFFFF_FFFC; step(); idle(); #1;
        total++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_plus4 got %h want 0", pc_plus4); else passed++;
        step();
        total++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h want 0", pc); else passed++;
        jump = 1; target = 32'h500; step(); idle();
        total++; if ({pc, fetch_valid} !== {32'h500, 1'b0}) $display("FAIL rr_recover got %h/%b want 500/0", pc, fetch_valid); else passed++;
        rst = 1; jump = 1; target = 32'h600; #1;
        total++; if (flush_ifid !== 1'b0) $display("FAIL rr_flush got %b want 0", flush_ifid); else passed++;
        step(); rst = 0; idle(); #1;
        total++; if ({pc, redirect_count} !== {32'h0, 16'd0}) $display("FAIL rr_state got %h/%0d want 0/0", pc, redirect_count); else passed++;
        total++; if ({fetch_valid, halted} !== 2'b10) $display("FAIL rr_run got %b want 10", {fetch_valid, halted}); else passed++;
        step();
        total++; if (pc !== 32'h4) $display("FAIL rr_seq got %h want 4", pc); else passed++;
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_stall();
        test_misalign();
        test_back_to_back();
        test_saturate();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
